// File: rtl/muldiv_unit_r0_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: function codes,
// FSM state encoding and default widths.
package muldiv_unit_r0_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned FUNCT_W_DEF    = 6;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit_r0_sign.sv
// Sign conditioning: operand magnitudes on the way in, result negation and
// divide special cases on the way out. Purely combinational.
module muldiv_sign_r0
  import muldiv_unit_r0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] raw_hi,
  input  logic [DATA_WIDTH-1:0] raw_lo,
  output logic [DATA_WIDTH-1:0] abs_a,
  output logic [DATA_WIDTH-1:0] abs_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                    a_neg;
  logic                    b_neg;
  logic                    div_zero;
  logic                    ovf;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_neg;

  always_comb begin
    a_neg    = is_signed & a[DATA_WIDTH-1];
    b_neg    = is_signed & b[DATA_WIDTH-1];
    abs_a    = a_neg ? -a : a;
    abs_b    = b_neg ? -b : b;
    div_zero = (b == '0);
    ovf      = is_signed && (a == MIN_NEG) && (b == '1);
    prod     = {raw_hi, raw_lo};
    prod_neg = -prod;
    hi       = raw_hi;
    lo       = raw_lo;
    if (is_div) begin
      if (div_zero) begin
        hi = a;
        lo = '1;
      end else if (ovf) begin
        hi = '0;
        lo = MIN_NEG;
      end else begin
        // quotient truncates toward zero; remainder follows the dividend
        lo = (a_neg ^ b_neg) ? -raw_lo : raw_lo;
        hi = a_neg ? -raw_hi : raw_hi;
      end
    end else if (a_neg ^ b_neg) begin
      {hi, lo} = prod_neg;
    end
  end

endmodule

// File: rtl/muldiv_unit_r0.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, 32 steps per operation.
module muldiv_unit_r0
  import muldiv_unit_r0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned ALUFUNCT_WIDTH = FUNCT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ALUFUNCT_WIDTH-1:0] ALUfunct,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [DATA_WIDTH-1:0]     hi,
  output logic [DATA_WIDTH-1:0]     lo,
  output logic                      busy,
  output logic                      done,
  output logic                      stall
);

  localparam int unsigned             CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_MFHI  = ALUFUNCT_WIDTH'(F_MFHI);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_MTHI  = ALUFUNCT_WIDTH'(F_MTHI);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_MFLO  = ALUFUNCT_WIDTH'(F_MFLO);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_MTLO  = ALUFUNCT_WIDTH'(F_MTLO);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_MULT  = ALUFUNCT_WIDTH'(F_MULT);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_MULTU = ALUFUNCT_WIDTH'(F_MULTU);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_DIV   = ALUFUNCT_WIDTH'(F_DIV);
  localparam logic [ALUFUNCT_WIDTH-1:0] C_DIVU  = ALUFUNCT_WIDTH'(F_DIVU);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  signed_q, div_q;
  logic [DATA_WIDTH-1:0] acc_hi, acc_lo;
  logic [DATA_WIDTH-1:0] hi_q, lo_q;

  logic f_mfhi, f_mthi, f_mflo, f_mtlo, f_mult, f_multu, f_div, f_divu;
  logic is_md, known, running, accept;

  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [DATA_WIDTH-1:0] fin_hi, fin_lo;
  logic [DATA_WIDTH-1:0] src_hi, src_lo;
  logic [DATA_WIDTH-1:0] hi_nxt, lo_nxt;
  logic [DATA_WIDTH:0]   mul_sum, div_shift, div_diff;
  logic                  div_ge;

  always_comb begin
    f_mfhi  = (ALUfunct == C_MFHI);
    f_mthi  = (ALUfunct == C_MTHI);
    f_mflo  = (ALUfunct == C_MFLO);
    f_mtlo  = (ALUfunct == C_MTLO);
    f_mult  = (ALUfunct == C_MULT);
    f_multu = (ALUfunct == C_MULTU);
    f_div   = (ALUfunct == C_DIV);
    f_divu  = (ALUfunct == C_DIVU);
    is_md   = f_mult | f_multu | f_div | f_divu;
    known   = is_md | f_mfhi | f_mthi | f_mflo | f_mtlo;
    running = (state == ST_RUN);
    accept  = start && is_md && !running;
  end

  assign busy  = running;
  assign done  = (state == ST_FIN);
  assign stall = start && running && known;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    result = '0;
    if (!running) begin
      if (f_mfhi)      result = hi_q;
      else if (f_mflo) result = lo_q;
    end
  end

  muldiv_sign_r0 #(.DATA_WIDTH(DATA_WIDTH)) u_sign (
    .a         (a_q),
    .b         (b_q),
    .is_signed (signed_q),
    .is_div    (div_q),
    .raw_hi    (hi_nxt),
    .raw_lo    (lo_nxt),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .hi        (fin_hi),
    .lo        (fin_lo)
  );

  // The accumulator is cleared at start; the first step seeds it from the
  // magnitudes so the sign stage only needs to see latched operands.
  always_comb begin
    src_hi    = (cnt == '0) ? '0 : acc_hi;
    src_lo    = (cnt == '0) ? (div_q ? abs_a : abs_b) : acc_lo;
    mul_sum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, abs_a} : '0);
    div_shift = {src_hi, src_lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, abs_b};
    div_ge    = ~div_diff[DATA_WIDTH];
    if (div_q) begin
      hi_nxt = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
      lo_nxt = {src_lo[DATA_WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[DATA_WIDTH:1];
      lo_nxt = {mul_sum[0], src_lo[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      div_q    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= f_mult | f_div;
            div_q    <= f_div | f_divu;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            hi_q  <= fin_hi;
            lo_q  <= fin_lo;
            state <= ST_FIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // moves to HI/LO land after any mul/div write of the same edge
      if (start && !running && f_mthi) hi_q <= a;
      if (start && !running && f_mtlo) lo_q <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit_r0.sv
// Directed and random checks of muldiv_unit_r0 against a behavioural
// model, with expected HI/LO results queued at issue time.
module tb_muldiv_unit_r0;
  import muldiv_unit_r0_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  ALUfunct;
  logic [31:0] a, b, result, hi, lo;
  logic        busy, done, stall;

  logic [63:0] exp_q[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  muldiv_unit_r0 #(.DATA_WIDTH(32), .ALUFUNCT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUfunct(ALUfunct), .a(a), .b(b),
    .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r, p;
    logic [63:0] res;
    sx  = $signed(x);
    sy  = $signed(y);
    res = '0;
    case (f)
      F_MULTU: res = {32'h0, x} * {32'h0, y};
      F_MULT: begin
        p   = sx * sy;
        res = p;
      end
      F_DIVU: res = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      F_DIV: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input bit push);
    start    = 1'b1;
    ALUfunct = f;
    a        = x;
    b        = y;
    if (push) exp_q.push_back(model(f, x, y));
  endtask

  task automatic wait_done(input string tag, input bit chk_lat);
    int lat = 0;
    int nb  = 0;
    bit seen = 0;
    logic [63:0] e;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) seen = 1;
      else if (busy) nb++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (chk_lat) begin
      chk({tag, "_latency"}, 64'(lat), 64'd33);
      chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int ndone;
    logic [5:0] op;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; ALUfunct = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ALUfunct = F_MFHI;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    // unlisted function code is ignored
    @(negedge clk);
    start = 1'b1; ALUfunct = 6'h05; a = 32'hDEAD_BEEF;
    #1;
    chk("bad_stall", 64'(stall), 64'd0);
    chk("bad_result", 64'(result), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_hilo", {hi, lo}, 64'd0);

    // MTLO while idle, then MFLO
    start = 1'b1; ALUfunct = F_MTLO; a = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    ALUfunct = F_MFLO;
    #1;
    chk("mflo_result", 64'(result), 64'h1234);

    @(negedge clk);
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    wait_done("multu_max", 1);
    chk("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);

    issue(F_MULT, 32'hFFFFFFFD, 32'd5, 1);
    wait_done("mult_neg", 1);
    chk("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    issue(F_DIV, 32'hFFFFFFF9, 32'd2, 1);
    wait_done("div_b2b", 1);
    chk("div_b2b_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(F_DIVU, 32'd100, 32'd0, 1);
    wait_done("divu_zero", 1);
    chk("divu_zero_const", {hi, lo}, 64'h00000064_FFFFFFFF);

    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_done("div_ovf", 1);
    chk("div_ovf_const", {hi, lo}, 64'h00000000_80000000);

    // MTHI in FIN overrides the fresh mul result in HI only
    issue(F_MULTU, 32'h0001_0000, 32'h0003_0000, 1);
    wait_done("multu_fin", 1);
    start = 1'b1; ALUfunct = F_MTHI; a = 32'h0000_ABCD;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_fin_hilo", {hi, lo}, 64'h0000ABCD_00000000);
    chk("mthi_fin_busy", 64'(busy), 64'd0);

    // requests during RUN stall and have no effect
    issue(F_MULTU, 32'd3, 32'd4, 1);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b1; ALUfunct = F_MFLO;
    #1;
    chk("mflo_run_stall", 64'(stall), 64'd1);
    chk("mflo_run_result", 64'(result), 64'd0);
    @(negedge clk);
    chk("mflo_run_lo", 64'(lo), 64'd0);
    ALUfunct = F_MTLO; a = 32'h5555;
    #1;
    chk("mtlo_run_stall", 64'(stall), 64'd1);
    @(negedge clk);
    chk("mtlo_run_lo", 64'(lo), 64'd0);
    wait_done("multu_stalled", 0);
    chk("multu_stalled_const", {hi, lo}, 64'd12);

    // reset aborts a divide; reset beats start in the same cycle
    @(negedge clk);
    issue(F_DIVU, 32'd1000, 32'd7, 0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    issue(F_MULTU, 32'd9, 32'd9, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    issue(F_MULTU, 32'd6, 32'd7, 1);
    wait_done("multu_6x7", 1);
    chk("multu_6x7_const", {hi, lo}, 64'd42);

    // random back-to-back mix
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: op = F_MULT;
        1: op = F_MULTU;
        2: op = F_DIV;
        default: op = F_DIVU;
      endcase
      ra = $urandom;
      rb = (i % 5 == 3) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 300) : $urandom);
      issue(op, ra, rb, 1);
      wait_done("rand", 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
